// File: rtl/rl_fifo_1r1w_ctrl_if.sv
// Port bundle between the FIFO controller, its producer/consumer and the attached 1R1W RAM.
// Signal names keep the controller-side _i/_o suffixes so they line up with the block's port list.
interface rl_fifo_1r1w_ctrl_if #(
  parameter int unsigned ABITS = 10,
  parameter int unsigned DBITS = 32
);
  // Handshake: push_i is taken on a rising edge only while full_o is low, and pop_i only while
  // empty_o is low; there is no ready wire, the flags act as ready. Read data arrives one cycle
  // after an accepted pop and is qualified by the single-cycle dout_valid_o pulse.
  logic               push_i;
  logic [DBITS-1:0]   din_i;
  logic               pop_i;
  logic [DBITS-1:0]   dout_o;
  logic               dout_valid_o;
  logic               full_o;
  logic               empty_o;
  logic               almost_full_o;
  logic               almost_empty_o;
  logic [ABITS:0]     count_o;
  logic               overflow_o;
  logic               underflow_o;
  logic [ABITS-1:0]   ram_waddr_o;
  logic [DBITS-1:0]   ram_din_o;
  logic               ram_we_o;
  logic [(DBITS+7)/8-1:0] ram_be_o;
  logic [ABITS-1:0]   ram_raddr_o;
  logic [DBITS-1:0]   ram_dout_i;

  modport slave (
    input  push_i, din_i, pop_i, ram_dout_i,
    output dout_o, dout_valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o,
           ram_waddr_o, ram_din_o, ram_we_o, ram_be_o, ram_raddr_o
  );

  modport master (
    output push_i, din_i, pop_i, ram_dout_i,
    input  dout_o, dout_valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o,
           ram_waddr_o, ram_din_o, ram_we_o, ram_be_o, ram_raddr_o
  );
endinterface

// File: rtl/rl_fifo_1r1w_ctrl.sv
// Synchronous FIFO controller for a 1R1W RAM with a registered read address (1-cycle read latency).
// Owns pointers, occupancy and flags; turns push/pop into RAM write/read accesses.
module rl_fifo_1r1w_ctrl #(
  parameter int unsigned ABITS        = 10,
  parameter int unsigned DBITS        = 32,
  parameter int unsigned ALMOST_FULL  = 2**ABITS - 4,
  parameter int unsigned ALMOST_EMPTY = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  rl_fifo_1r1w_ctrl_if.slave bus
);

  localparam int unsigned    BBITS   = (DBITS + 7) / 8;
  localparam logic [ABITS:0] DEPTH_C = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0] AF_C    = ALMOST_FULL[ABITS:0];
  localparam logic [ABITS:0] AE_C    = ALMOST_EMPTY[ABITS:0];

  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS:0]   count;
  logic             dout_valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             full;
  logic             empty;
  logic             push_acc;
  logic             pop_acc;

  // Flags come from the registered count only, so a push while full is refused even when a pop
  // frees a slot in the same cycle; that keeps the write off the address being read.
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign push_acc = bus.push_i & ~full;
  assign pop_acc  = bus.pop_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      dout_valid_q <= pop_acc;
      overflow_q   <= bus.push_i & full;
      underflow_q  <= bus.pop_i & empty;
    end
  end

  // The valid pulse is also masked while reset is held, so a pop followed by reset shows no data.
  assign bus.dout_o         = bus.ram_dout_i;
  assign bus.dout_valid_o   = dout_valid_q & rst_ni;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (count >= AF_C);
  assign bus.almost_empty_o = (count <= AE_C);
  assign bus.count_o        = count;
  assign bus.overflow_o     = overflow_q;
  assign bus.underflow_o    = underflow_q;

  assign bus.ram_waddr_o = wr_ptr;
  assign bus.ram_din_o   = bus.din_i;
  assign bus.ram_we_o    = push_acc & rst_ni;
  assign bus.ram_be_o    = {BBITS{1'b1}};
  assign bus.ram_raddr_o = rd_ptr;

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Bench for rl_fifo_1r1w_ctrl (ABITS=3): directed scenarios plus random traffic against a queue model.
module tb_rl_fifo_1r1w_ctrl;

  localparam int unsigned ABITS = 3;
  localparam int unsigned DBITS = 32;
  localparam int          DEPTH = 8;
  localparam int          AF    = DEPTH - 4;
  localparam int          AE    = 4;

  logic clk;
  logic rst_n;

  rl_fifo_1r1w_ctrl_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

  rl_fifo_1r1w_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural 1R1W RAM: registered read address, combinational data out
  logic [DBITS-1:0] mem [DEPTH];
  logic [ABITS-1:0] raddr_q;
  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_waddr_o] <= bus.ram_din_o;
    raddr_q <= bus.ram_raddr_o;
  end
  assign bus.ram_dout_i = mem[raddr_q];

  // scoreboard / reference model
  logic [DBITS-1:0] exp_q[$];
  logic             pend_valid;
  logic [DBITS-1:0] pend_data;
  logic             ovf_e;
  logic             unf_e;
  int               wr_cnt;
  int               rd_cnt;
  int               n_checks;
  int               n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: one clock cycle with the given inputs; checks mid-cycle, updates the model at the edge
  task automatic drive(input logic r, input logic p, input logic [DBITS-1:0] d, input logic q);
    int  sz;
    logic m_full, m_empty;
    rst_n      = r;
    bus.push_i = p;
    bus.din_i  = d;
    bus.pop_i  = q;
    @(negedge clk);
    sz      = exp_q.size();
    m_full  = (sz == DEPTH);
    m_empty = (sz == 0);
    check_eq("count",        64'(bus.count_o), 64'(sz));
    check_eq("empty",        64'(bus.empty_o), 64'(m_empty));
    check_eq("full",         64'(bus.full_o), 64'(m_full));
    check_eq("almost_full",  64'(bus.almost_full_o), 64'(sz >= AF));
    check_eq("almost_empty", 64'(bus.almost_empty_o), 64'(sz <= AE));
    check_eq("overflow",     64'(bus.overflow_o), 64'(ovf_e));
    check_eq("underflow",    64'(bus.underflow_o), 64'(unf_e));
    check_eq("dout_valid",   64'(bus.dout_valid_o), 64'(pend_valid && r));
    if (pend_valid && r) check_eq("dout", 64'(bus.dout_o), 64'(pend_data));
    check_eq("ram_we",       64'(bus.ram_we_o), 64'(r && p && !m_full));
    if (r && p && !m_full) begin
      check_eq("ram_waddr", 64'(bus.ram_waddr_o), 64'(wr_cnt % DEPTH));
      check_eq("ram_din",   64'(bus.ram_din_o), 64'(d));
    end
    check_eq("ram_raddr",    64'(bus.ram_raddr_o), 64'(rd_cnt % DEPTH));
    check_eq("ram_be",       64'(bus.ram_be_o), 64'(4'hF));
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
      pend_valid = 1'b0;
      ovf_e      = 1'b0;
      unf_e      = 1'b0;
      wr_cnt     = 0;
      rd_cnt     = 0;
    end else begin
      pend_valid = q && !m_empty;
      if (q && !m_empty) begin
        pend_data = exp_q.pop_front();
        rd_cnt++;
      end
      if (p && !m_full) begin
        exp_q.push_back(d);
        wr_cnt++;
      end
      ovf_e = p && m_full;
      unf_e = q && m_empty;
    end
    #1;
  endtask

  initial begin
    int pp;
    int qp;
    n_checks   = 0;
    n_errors   = 0;
    pend_valid = 1'b0;
    pend_data  = '0;
    ovf_e      = 1'b0;
    unf_e      = 1'b0;
    wr_cnt     = 0;
    rd_cnt     = 0;
    rst_n      = 1'b0;
    bus.push_i = 1'b0;
    bus.din_i  = '0;
    bus.pop_i  = 1'b0;
    @(posedge clk);
    #1;

    // reset held with push asserted
    drive(1'b0, 1'b1, 32'hDEAD, 1'b0);
    drive(1'b0, 1'b1, 32'hBEEF, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);

    // push A0..A3, pop back-to-back
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'hA0 + i, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);

    // fill to full across the pointer wrap, push+pop while full, drain
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 32'hB0 + i, 1'b0);
    drive(1'b1, 1'b1, 32'hBF, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);

    // push+pop on empty
    drive(1'b1, 1'b1, 32'h55, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);

    // steady half-full streaming
    for (int i = 0; i < DEPTH / 2; i++) drive(1'b1, 1'b1, $urandom, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) drive(1'b1, 1'b1, $urandom, 1'b1);
    for (int i = 0; i < DEPTH / 2 + 1; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);

    // reset the cycle after a pop
    drive(1'b1, 1'b1, 32'hC0, 1'b0);
    drive(1'b1, 1'b1, 32'hC1, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h66, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);

    // random traffic with shifting push/pop bias and rare resets
    pp = 50;
    qp = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        pp = $urandom_range(20, 90);
        qp = $urandom_range(20, 90);
      end
      drive($urandom_range(0, 79) != 0, $urandom_range(0, 99) < pp, $urandom,
            $urandom_range(0, 99) < qp);
    end
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
